// File: rtl/pixel_stream_pkg.sv
// Shared types and coordinate-width constants for the pixel tracker and the crop stage.
package pixel_stream_pkg;

  typedef enum logic [0:0] {
    SEEK     = 1'b0,
    IN_FRAME = 1'b1
  } trk_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_PIXEL_BIT_WIDTH = 10;
  localparam int DEF_IN_ROWS         = 20;
  localparam int DEF_IN_COLS         = 20;
  localparam int DEF_FRAME_CNT_W     = 16;
  localparam int DEF_COL_W           = coord_w(DEF_IN_COLS);
  localparam int DEF_ROW_W           = coord_w(DEF_IN_ROWS);
  localparam int STATS_W             = 16;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with synchronous clear and increment; clear then increment restarts at 1.
module wrap_counter
  import pixel_stream_pkg::*;
#(
  parameter int MODULUS = 20,
  parameter int W       = coord_w(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base   = clr_i ? '0 : cnt_q;
    wrap_o = inc_i && (base == W'(MODULUS - 1));
    cnt_d  = base;
    if (inc_i) cnt_d = wrap_o ? '0 : base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/pixel_coord_tracker.sv
// SOF-locked pixel pass-through that tracks raster coordinates for the crop stage.
// Optional error/drop statistics are enabled with PIXEL_COORD_TRACKER_STATS_EN.
//
// state    | meaning
// SEEK     | out of lock; non-SOF beats are dropped, an SOF beat is forwarded and locks
// IN_FRAME | locked; beats forwarded and counted, malformed SOF flagged
module pixel_coord_tracker
  import pixel_stream_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int IN_ROWS         = DEF_IN_ROWS,
  parameter int IN_COLS         = DEF_IN_COLS,
  parameter int FRAME_CNT_W     = DEF_FRAME_CNT_W,
  localparam int COL_W          = coord_w(IN_COLS),
  localparam int ROW_W          = coord_w(IN_ROWS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic [COL_W-1:0]           cnt_col,
  output logic [ROW_W-1:0]           cnt_row,
  output logic                       eol,
  output logic                       eof,
  output logic                       locked,
  output logic [FRAME_CNT_W-1:0]     frame_cnt,
  output logic                       err_early_sof,
  output logic                       err_missing_sof
`ifdef PIXEL_COORD_TRACKER_STATS_EN
  ,
  output logic [STATS_W-1:0]         early_sof_cnt,
  output logic [STATS_W-1:0]         missing_sof_cnt,
  output logic [STATS_W-1:0]         dropped_px_cnt
`endif
);

  trk_state_t             state_q, state_d;
  logic [COL_W-1:0]       col_q;
  logic [ROW_W-1:0]       row_q;
  logic                   col_wrap, row_wrap;
  logic                   at_origin;
  logic                   restart, advance, early_sof, missing_sof;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   err_early_q, err_missing_q;

  assign at_origin = (col_q == '0) && (row_q == '0);

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    restart       = 1'b0;
    advance       = 1'b0;
    early_sof     = 1'b0;
    missing_sof   = 1'b0;
    case (state_q)
      SEEK: begin
        // The SOF beat is real data, so it honours downstream backpressure.
        if (s_axis_tuser) begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          if (s_axis_tvalid && m_axis_tready) begin
            restart = 1'b1;
            state_d = IN_FRAME;
          end
        end
      end
      IN_FRAME: begin
        if (!s_axis_tuser && at_origin) begin
          missing_sof = s_axis_tvalid;
          if (s_axis_tvalid) state_d = SEEK;
        end else begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          if (s_axis_tvalid && m_axis_tready) begin
            if (s_axis_tuser) begin
              restart   = 1'b1;
              early_sof = !at_origin;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  wrap_counter #(.MODULUS(IN_COLS), .W(COL_W)) u_col (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (restart),
    .inc_i  (restart | advance),
    .q_o    (col_q),
    .wrap_o (col_wrap)
  );

  wrap_counter #(.MODULUS(IN_ROWS), .W(ROW_W)) u_row (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (restart),
    .inc_i  (col_wrap),
    .q_o    (row_q),
    .wrap_o (row_wrap)
  );

  assign frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(row_wrap);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEEK;
      frame_cnt_q   <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      err_early_q   <= early_sof;
      err_missing_q <= missing_sof;
    end
  end

  assign m_axis_tdata    = s_axis_tdata;
  assign cnt_col         = s_axis_tuser ? '0 : col_q;
  assign cnt_row         = s_axis_tuser ? '0 : row_q;
  assign locked          = (state_q == IN_FRAME);
  assign eol             = locked && (cnt_col == COL_W'(IN_COLS - 1));
  assign eof             = eol && (cnt_row == ROW_W'(IN_ROWS - 1));
  assign frame_cnt       = frame_cnt_q;
  assign err_early_sof   = err_early_q;
  assign err_missing_sof = err_missing_q;

`ifdef PIXEL_COORD_TRACKER_STATS_EN
  logic [STATS_W-1:0] early_cnt_q, missing_cnt_q, drop_cnt_q;
  logic               drop;

  // Accepted but not forwarded: SEEK junk and the missing-SOF beat.
  assign drop = s_axis_tvalid && s_axis_tready && !m_axis_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      early_cnt_q   <= '0;
      missing_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (early_sof && early_cnt_q != '1)     early_cnt_q   <= early_cnt_q + 1'b1;
      if (missing_sof && missing_cnt_q != '1) missing_cnt_q <= missing_cnt_q + 1'b1;
      if (drop && drop_cnt_q != '1)           drop_cnt_q    <= drop_cnt_q + 1'b1;
    end
  end

  assign early_sof_cnt   = early_cnt_q;
  assign missing_sof_cnt = missing_cnt_q;
  assign dropped_px_cnt  = drop_cnt_q;
`endif

endmodule

// File: doc/pixel_coord_tracker.md
# pixel_coord_tracker

Upstream companion of the crop stage in the frame pipeline. Sits between the camera pixel stream and the crop filter, and does four jobs:
- Passes pixels through with zero latency.
- Counts accepted beats into column/row coordinates, which drive the crop filter's `cnt_col`/`cnt_row` inputs.
- Locks onto start-of-frame markers.
- Discards pixels while out of lock, and flags malformed frames (early or missing SOF).

## Interface
- `PIXEL_BIT_WIDTH`, 10: pixel data width.
- `IN_ROWS`, 20: rows per frame; must be ≥2.
- `IN_COLS`, 20: columns per frame; must be ≥2.
- `FRAME_CNT_W`, 16: frame counter width.

- `clk`  in  1: pipeline clock.
- `rst`  in  1: synchronous, active-high reset.
- `s_axis_tvalid`  in  1: upstream pixel valid.
- `s_axis_tready`  out  1: upstream ready.
- `s_axis_tdata`  in  PIXEL_BIT_WIDTH: pixel.
- `s_axis_tuser`  in  1: SOF marker; set on pixel (0,0).
- `m_axis_tvalid`  out  1: pixel valid to crop stage.
- `m_axis_tready`  in  1: crop-stage ready.
- `m_axis_tdata`  out  PIXEL_BIT_WIDTH: pixel.
- `cnt_col`  out  $clog2(IN_COLS): column of the beat currently on `s_axis`.
- `cnt_row`  out  $clog2(IN_ROWS): row of the beat currently on `s_axis`.
- `eol`  out  1: current beat is the last column.
- `eof`  out  1: current beat is the last pixel of the frame.
- `locked`  out  1: state is IN_FRAME.
- `frame_cnt`  out  FRAME_CNT_W: completed frames, wraps.
- `err_early_sof`  out  1: one-cycle pulse.
- `err_missing_sof`  out  1: one-cycle pulse.

## Operation
- Accept = `s_axis_tvalid && s_axis_tready`.
- State machine (2 states):
  - SEEK, the reset state.
    - `s_axis_tready`=1 and `m_axis_tvalid`=0, so pixels are dropped.
    - An accepted beat with `tuser`=1 → IN_FRAME; that beat is forwarded as (0,0).
  - IN_FRAME.
    - `s_axis_tready`=`m_axis_tready`.
    - `m_axis_tvalid`=`s_axis_tvalid`.
    - `m_axis_tdata`=`s_axis_tdata`.
- Coordinates:
  - Registered `col_q`/`row_q`.
  - `cnt_col`/`cnt_row` = 0 when `s_axis_tuser`=1, else `col_q`/`row_q`.
  - On accept in IN_FRAME: col increments and wraps at IN_COLS-1 to 0, with a row increment.
  - Row wraps at IN_ROWS-1 to 0, and `frame_cnt` increments (mod 2^FRAME_CNT_W).
- Early SOF:
  - Condition: accepted beat with `tuser`=1 in IN_FRAME while `col_q`≠0 or `row_q`≠0.
  - `err_early_sof` pulses the next cycle.
  - The beat is forwarded as (0,0) and the counters restart at (0,1 col); `frame_cnt` is not incremented.
- Missing SOF:
  - Condition: accepted beat with `tuser`=0 in IN_FRAME at `col_q`=0, `row_q`=0.
  - `err_missing_sof` pulses the next cycle.
  - The beat is dropped: `m_axis_tvalid` forced 0 that cycle, `s_axis_tready`=1.
  - State → SEEK.
- `eol`/`eof` are combinational from the displayed coordinates and qualified by `locked`.

## Timing
- Data path: zero latency, purely combinational.
- Counters, state, `frame_cnt` and error pulses update on the rising `clk` edge after an accept.
- Reset values:
  - State SEEK, `col_q`=`row_q`=0, `frame_cnt`=0.
  - Error pulses 0, `locked`=0, `m_axis_tvalid`=0, `s_axis_tready`=1.
- Reset mid-frame: the next cycle is in SEEK and the partial frame is discarded; `frame_cnt` is not incremented.
- Backpressure: with `m_axis_tready`=0 in IN_FRAME, there is no accept, counters hold, and the outputs stay stable.
- `tvalid`=0 cycles never advance state or counters.
- Last-pixel wrap and a `tuser` on the next beat form the normal case: no error.

## Configuration
- `PIXEL_COORD_TRACKER_STATS_EN` defined:
  - Adds 16-bit saturating outputs `early_sof_cnt`, `missing_sof_cnt` and `dropped_px_cnt` (beats dropped in SEEK or on missing SOF).
  - All three reset to 0.
- Undefined: these ports and counters are absent; everything else is identical.

## Structure
- Package `pixel_stream_pkg`:
  - State enum `trk_state_t` {SEEK, IN_FRAME}.
  - Helper function for coordinate widths.
  - Crop stage shares the coordinate width constants.
- Sub-module `wrap_counter` (parameterised modulus, enable, wrap-out), instantiated twice: column, and row chained on column wrap.

## Test plan
- Reset, then 3 clean 20×20 frames with `tuser` on the first pixel, `m_axis_tready`=1 → 1200 pixels forwarded, `cnt_col`/`cnt_row` match the raster, `eof` 3 times, `frame_cnt`=3, no errors.
- 5 beats with `tuser`=0, then SOF → 5 beats dropped (`m_axis_tvalid`=0, `s_axis_tready`=1), `locked` rises on the SOF beat, first forwarded coordinate (0,0).
- `tuser`=1 at (7,3) mid-frame → `err_early_sof` single pulse, that pixel reported as (0,0), `frame_cnt` unchanged, next pixel at (1,0).
- Frame ends, next beat has `tuser`=0 → `err_missing_sof` pulse, beat dropped, `locked`=0, resync on the next SOF.
- Random `m_axis_tready` toggling (50%) over 2 frames → no pixel duplicated or lost, coordinates advance only on accept, `frame_cnt`=2.
- `rst` asserted at (10,5) → next cycle SEEK, `cnt` reads 0, `frame_cnt` held at 0; with STATS_EN, check `dropped_px_cnt` equals the beats sent before the SOF.
